restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider_if.sv | 24 ++
 rtl/restoring_divider.sv | 90 +++++++++
 tb/tb_restoring_divider.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/restoring_divider_if.sv
// Launch/result signal bundle for the restoring divider.
// The master launches divisions; the slave (divider) returns registered results.
interface restoring_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             fin;
    logic             dz;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, fin, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, fin, dz
    );
endinterface

// File: rtl/restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock over WIDTH cycles.
// Divide-by-zero bypasses iteration and reports all-ones quotient with dz set.
module restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    restoring_divider_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    // After each restore A < M, so the partial remainder never needs its top bit
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  m;
    logic [CW-1:0]     count;

    logic [WIDTH:0]    a_sh_c;
    logic [WIDTH:0]    trial_c;
    logic [WIDTH-1:0]  a_next_c;
    logic [WIDTH-1:0]  q_next_c;
    logic              accept_c;

    // One shift/subtract/restore step
    always_comb begin
        a_sh_c   = {a, q[WIDTH-1]};
        trial_c  = a_sh_c - {1'b0, m};
        a_next_c = trial_c[WIDTH] ? a_sh_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
        q_next_c = {q[WIDTH-2:0], ~trial_c[WIDTH]};
        accept_c = bus.start && (state != CALC);
    end

    // busy/fin are registered decodes of the state, so they trail it by one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            a             <= '0;
            q             <= '0;
            m             <= '0;
            count         <= '0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.dz        <= 1'b0;
            bus.busy      <= 1'b0;
            bus.fin       <= 1'b0;
        end else begin
            bus.busy <= (state == CALC);
            bus.fin  <= (state == DONE);
            case (state)
                IDLE, DONE: begin
                    if (accept_c) begin
                        if (bus.divisor == '0) begin
                            bus.quotient  <= '1;
                            bus.remainder <= bus.dividend;
                            bus.dz        <= 1'b1;
                            state         <= DONE;
                        end else begin
                            a      <= '0;
                            q      <= bus.dividend;
                            m      <= bus.divisor;
                            count  <= CW'(WIDTH);
                            bus.dz <= 1'b0;
                            state  <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    a     <= a_next_c;
                    q     <= q_next_c;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        bus.quotient  <= q_next_c;
                        bus.remainder <= a_next_c;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider (WIDTH=8): directed vectors, a held-start
// burst, a mid-operation reset and a short random sweep against an arithmetic model.
module tb_restoring_divider;
    localparam int unsigned WIDTH = 8;

    typedef struct {
        int q;
        int r;
        int dz;
        int fin_edge;
    } exp_t;

    logic clk;
    logic rst_n;
    int   edge_cnt;
    int   n_checks;
    int   n_fail;
    int   fin_seen;
    int   n_pushed;
    exp_t sb[$];
    exp_t mon_e;

    restoring_divider_if #(.WIDTH(WIDTH)) bus ();

    restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Model: expected result and the edge after which fin is seen
    task automatic push_exp(input int a, input int b, input int k);
        exp_t e;
        if (b == 0) begin
            e.q = 255; e.r = a; e.dz = 1; e.fin_edge = k + 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 0; e.fin_edge = k + WIDTH + 1;
        end
        sb.push_back(e);
        n_pushed++;
    endtask

    // Single-cycle start from a negedge; operands are scrambled right after acceptance
    task automatic issue(input int a, input int b, input bit expect_result);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'(a);
        bus.divisor  = 8'(b);
        if (expect_result) push_exp(a, b, edge_cnt + 1);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
    endtask

    task automatic run_op(input int a, input int b, input bit chk_busy);
        int busy_cycles;
        busy_cycles = 0;
        issue(a, b, 1'b1);
        repeat (WIDTH + 2) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
        end
        if (chk_busy) check("busy_cycles", busy_cycles, (b == 0) ? 0 : WIDTH);
    endtask

    // Monitor: every fin pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.fin) begin
            fin_seen++;
            if (sb.size() == 0) begin
                check("unexpected_fin", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", int'(bus.quotient), mon_e.q);
                check("remainder", int'(bus.remainder), mon_e.r);
                check("dz", int'(bus.dz), mon_e.dz);
                check("fin_latency", edge_cnt, mon_e.fin_edge);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        n_checks = 0; n_fail = 0; fin_seen = 0; n_pushed = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_quotient", int'(bus.quotient), 0);
        check("rst_remainder", int'(bus.remainder), 0);
        check("rst_dz", int'(bus.dz), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_fin", int'(bus.fin), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        run_op(100, 7, 1'b1);
        run_op(255, 1, 1'b1);
        run_op(3, 10, 1'b1);
        run_op(5, 0, 1'b1);
        run_op(100, 7, 1'b1);
        run_op(0, 5, 1'b0);
        run_op(255, 255, 1'b0);
        run_op(0, 0, 1'b1);
        run_op(128, 3, 1'b0);

        // start held high: re-accepted only in DONE, every 9 edges
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd9;
        k0 = edge_cnt + 1;
        push_exp(200, 9, k0);
        push_exp(200, 9, k0 + 9);
        push_exp(200, 9, k0 + 18);
        repeat (19) @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        // Reset on the edge ending the 4th CALC cycle aborts the operation
        issue(100, 7, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_fin", int'(bus.fin), 0);
        check("abort_quotient", int'(bus.quotient), 0);
        check("abort_remainder", int'(bus.remainder), 0);
        check("abort_dz", int'(bus.dz), 0);
        repeat (12) @(negedge clk);
        run_op(50, 6, 1'b1);

        // Random sweep, with an occasional zero divisor
        for (int i = 0; i < 150; i++) begin
            int a;
            int b;
            a = int'($urandom_range(255, 0));
            b = (i % 16 == 0) ? 0 : int'($urandom_range(255, 0));
            run_op(a, b, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("fin_count", fin_seen, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
